program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction loader that sits directly upstream of the single-cycle core's program memory. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and writes them to sequential word addresses through the program memory write port. It holds the core in reset until the image is fully loaded. The core starts fetching at PC 0 only after a clean load.

## Interface
Parameters:
- PROGRAM_MEMORY_DEPTH, 64, program memory size in 32-bit words; maximum loadable word count.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start_i  input  1  begin a load; sampled in IDLE, DONE and ERROR.
- Byte_Valid_i  input  1  Byte_Data_i holds a valid byte.
- Byte_Data_i  input  8  stream byte.
- Byte_Ready_o  output  1  loader accepts a byte this cycle.
- Mem_Write_o  output  1  one-cycle write strobe to program memory.
- Mem_Address_o  output  32  byte address of the word being written (word index × 4).
- Mem_Data_o  output  32  assembled instruction word.
- Core_Reset_o  output  1  reset to the core (PC register, register file); high unless DONE.
- Done_o  output  1  image loaded and core released.
- Error_o  output  1  load aborted; core kept in reset.

## Operation
- Stream format: word count N (16-bit, low byte first), then N×4 instruction bytes, each word low byte first (byte k → bits 8k+7:8k).
- States: IDLE, HDR_LO, HDR_HI, LOAD, WRITE, DONE, ERROR (plus CHECK when the checksum is enabled).
- IDLE: Start_i=1 → HDR_LO.
- HDR_LO: accepting N[7:0] → HDR_HI.
- HDR_HI: accepting N[15:8] → LOAD. If the 16-bit N is 0 or greater than PROGRAM_MEMORY_DEPTH, go to ERROR instead.
- LOAD: each accepted byte is shifted into its lane; a 2-bit byte counter advances. The 4th byte → WRITE.
- WRITE: Mem_Write_o=1 for exactly one cycle, with Mem_Address_o = idx<<2 and Mem_Data_o = assembled word. Then idx increments.
  - If idx+1 < N → LOAD.
  - Otherwise → DONE, or → CHECK when the checksum is enabled.
- DONE: Core_Reset_o=0, Done_o=1. Held until reset or Start_i.
- ERROR: Error_o=1, Core_Reset_o=1. Held until reset or Start_i.
- Start_i=1 in DONE or ERROR: → HDR_LO. This clears idx, the byte counter, Done_o and Error_o, and reasserts Core_Reset_o the following cycle.
- Start_i is ignored in every other state.
- Byte acceptance happens only on a rising edge with Byte_Valid_i & Byte_Ready_o. Byte_Valid_i without Ready is ignored; the byte is not consumed.
- Byte_Ready_o=1 in HDR_LO, HDR_HI, LOAD (and CHECK when enabled). It is 0 in all other states, including WRITE.
- Word index width: $clog2(PROGRAM_MEMORY_DEPTH)+1 bits, so idx==DEPTH is representable. Upper address bits are zero.

## Timing
- Reset values: Byte_Ready_o=0, Mem_Write_o=0, Mem_Address_o=0, Mem_Data_o=0, Core_Reset_o=1, Done_o=0, Error_o=0. State returns to IDLE; idx, byte counter and checksum are cleared.
- Reset dominates all inputs, including mid-load; a partially written image is not reverted.
- All outputs are decoded from registered state and datapath registers; there is no combinational input-to-output path.
- Byte throughput: at most one byte per cycle in LOAD. Each word costs 4 accept cycles plus 1 WRITE cycle.
- Minimum load time from Start_i to Done_o: 1 (start) + 2 (header) + 5N cycles, with Byte_Valid_i held high throughout.
- Mem_Address_o and Mem_Data_o are stable during the WRITE cycle and hold their values afterward until the next WRITE.
- Core_Reset_o falls in the same cycle Done_o rises. Core reset is synchronous, so the core's first fetch at PC 0 occurs on the next edge.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last WRITE the loader enters CHECK and accepts one extra byte.
  - It compares that byte against the XOR of all 4N instruction bytes (header bytes excluded).
  - Match → DONE; mismatch → ERROR. Words are already written either way; the core stays in reset on mismatch.
- LOADER_CHECKSUM_EN undefined: no CHECK state and no checksum register; the last WRITE goes straight to DONE.

## Test plan
- Reset then Start_i, stream 02 00 | 93 00 50 00 | 13 01 31 00, valid held high:
  - writes 0x00500093 @0x0 and 0x00310113 @0x4, one strobe each;
  - Done_o=1 and Core_Reset_o=0 after 13 cycles.
- Header N=0 (00 00) → Error_o=1, no Mem_Write_o, Core_Reset_o stays 1, Byte_Ready_o=0. Header N=65 with depth 64 → same result.
- Load N=64 with random valid gaps → exactly 64 strobes, last address 0xFC, each byte consumed exactly once.
- Assert reset during byte 3 of word 1 → all outputs at reset values next cycle. A fresh 1-word load afterward writes at address 0x0.
- Start_i in DONE → Core_Reset_o=1, Done_o=0 next cycle; a reload proceeds from HDR_LO.
- With LOADER_CHECKSUM_EN, 1-word load 78 56 34 12 + checksum 08 → DONE. The same load with checksum 09 → ERROR, with the word still written at 0x0.

Source files
------------

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time instruction loader placed in front of the core's program memory.
// It takes a byte stream over a valid/ready handshake, builds little-endian
// 32-bit instructions, and writes them to consecutive word addresses. The core
// is held in reset until a complete image has been loaded.
//
// Stream layout: word count N (16-bit, low byte first), then N x 4 instruction
// bytes, each word low byte first. N must be in 1..PROGRAM_MEMORY_DEPTH.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   After the last word, one extra byte is accepted and compared against the
//   XOR of all instruction bytes. Match -> DONE, mismatch -> ERROR.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   Start_i        begin a load (honoured in IDLE, DONE and ERROR)
//   Byte_Valid_i   Byte_Data_i carries a valid byte
//   Byte_Data_i    stream byte
//   Byte_Ready_o   loader will accept a byte on this edge
//   Mem_Write_o    one-cycle program memory write strobe
//   Mem_Address_o  byte address of the word being written (index * 4)
//   Mem_Data_o     assembled instruction word
//   Core_Reset_o   core reset, high unless the image is loaded
//   Done_o         image loaded, core released
//   Error_o        load aborted, core kept in reset
// ---------------------------------------------------------------------------
module program_loader #(
   parameter int PROGRAM_MEMORY_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start_i,
   input  logic        Byte_Valid_i,
   input  logic [7:0]  Byte_Data_i,
   output logic        Byte_Ready_o,
   output logic        Mem_Write_o,
   output logic [31:0] Mem_Address_o,
   output logic [31:0] Mem_Data_o,
   output logic        Core_Reset_o,
   output logic        Done_o,
   output logic        Error_o
);

   // One extra bit so that an index equal to the depth is representable.
   localparam int IDX_W = $clog2(PROGRAM_MEMORY_DEPTH) + 1;

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_HDR_LO, S_HDR_HI, S_LOAD, S_WRITE, S_DONE, S_ERROR, S_CHECK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_HDR_LO, S_HDR_HI, S_LOAD, S_WRITE, S_DONE, S_ERROR
   } state_t;
`endif

   state_t            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [1:0]        byte_cnt_q;
   logic [7:0]        count_lo_q;
   logic [15:0]       word_count_q;
   logic [23:0]       word_q;        // lanes 0..2; lane 3 arrives with the write
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic              ready_q;
   logic              mem_write_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       mem_data_q;
   logic              core_reset_q;
   logic              done_q;
   logic              error_q;

   logic              accept;
   logic [15:0]       hdr_n;
   logic              hdr_bad;
   logic              last_word;

   // Ready is a registered flag, so acceptance never depends combinationally
   // on an output derived from the inputs.
   assign accept    = Byte_Valid_i & ready_q;
   assign hdr_n     = {Byte_Data_i, count_lo_q};
   assign hdr_bad   = (hdr_n == 16'd0) ||
                      ({16'd0, hdr_n} > 32'(PROGRAM_MEMORY_DEPTH));
   assign last_word = ({{(32-IDX_W){1'b0}}, idx_q} + 32'd1) >= {16'd0, word_count_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         byte_cnt_q   <= 2'd0;
         count_lo_q   <= 8'd0;
         word_count_q <= 16'd0;
         word_q       <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_q       <= 8'd0;
`endif
         ready_q      <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_data_q   <= 32'd0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         // NOTE: every state element here uses <= so all registers update from
         // the same pre-edge values; a blocking = would leak new values into
         // later statements of this block.
         mem_write_q <= 1'b0;

         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (Start_i) begin
                  state_q      <= S_HDR_LO;
                  idx_q        <= '0;
                  byte_cnt_q   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                  csum_q       <= 8'd0;
`endif
                  ready_q      <= 1'b1;
                  core_reset_q <= 1'b1;
                  done_q       <= 1'b0;
                  error_q      <= 1'b0;
               end
            end

            S_HDR_LO: begin
               if (accept) begin
                  count_lo_q <= Byte_Data_i;
                  state_q    <= S_HDR_HI;
               end
            end

            S_HDR_HI: begin
               if (accept) begin
                  if (hdr_bad) begin
                     state_q <= S_ERROR;
                     ready_q <= 1'b0;
                     error_q <= 1'b1;
                  end else begin
                     word_count_q <= hdr_n;
                     state_q      <= S_LOAD;
                  end
               end
            end

            S_LOAD: begin
               if (accept) begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum_q     <= csum_q ^ Byte_Data_i;
`endif
                  case (byte_cnt_q)
                     2'd0:    word_q[7:0]   <= Byte_Data_i;
                     2'd1:    word_q[15:8]  <= Byte_Data_i;
                     2'd2:    word_q[23:16] <= Byte_Data_i;
                     default: begin
                        // Fourth byte completes the word: present it to memory.
                        state_q     <= S_WRITE;
                        ready_q     <= 1'b0;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
                        mem_data_q  <= {Byte_Data_i, word_q};
                     end
                  endcase
               end
            end

            S_WRITE: begin
               idx_q <= idx_q + 1'b1;
               if (!last_word) begin
                  state_q <= S_LOAD;
                  ready_q <= 1'b1;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  state_q <= S_CHECK;
                  ready_q <= 1'b1;
`else
                  state_q      <= S_DONE;
                  core_reset_q <= 1'b0;
                  done_q       <= 1'b1;
`endif
               end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  if (Byte_Data_i == csum_q) begin
                     state_q      <= S_DONE;
                     core_reset_q <= 1'b0;
                     done_q       <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign Byte_Ready_o  = ready_q;
   assign Mem_Write_o   = mem_write_q;
   assign Mem_Address_o = mem_addr_q;
   assign Mem_Data_o    = mem_data_q;
   assign Core_Reset_o  = core_reset_q;
   assign Done_o        = done_q;
   assign Error_o       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. A reference model derives the
// expected write list and final outcome straight from the byte stream; a
// monitor collects the writes the DUT actually performs. Honours
// LOADER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_program_loader;

   localparam int DEPTH = 64;
`ifdef LOADER_CHECKSUM_EN
   localparam int CSUM_EXTRA = 1;
`else
   localparam int CSUM_EXTRA = 0;
`endif

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic        Start_i;
   logic        Byte_Valid_i;
   logic [7:0]  Byte_Data_i;
   logic        Byte_Ready_o;
   logic        Mem_Write_o;
   logic [31:0] Mem_Address_o;
   logic [31:0] Mem_Data_o;
   logic        Core_Reset_o;
   logic        Done_o;
   logic        Error_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   program_loader #(.PROGRAM_MEMORY_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .Start_i       (Start_i),
      .Byte_Valid_i  (Byte_Valid_i),
      .Byte_Data_i   (Byte_Data_i),
      .Byte_Ready_o  (Byte_Ready_o),
      .Mem_Write_o   (Mem_Write_o),
      .Mem_Address_o (Mem_Address_o),
      .Mem_Data_o    (Mem_Data_o),
      .Core_Reset_o  (Core_Reset_o),
      .Done_o        (Done_o),
      .Error_o       (Error_o)
   );

   always #5 clk = ~clk;

   // Monitor: capture write strobes and check invariants mid-cycle.
   always @(negedge clk) begin
      if (Mem_Write_o === 1'b1) begin
         wr_addr_q.push_back(Mem_Address_o);
         wr_data_q.push_back(Mem_Data_o);
         checks++;
         if (Byte_Ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_write: Byte_Ready_o=%b required 0", Byte_Ready_o);
         end
      end
      if (reset === 1'b0) begin
         checks++;
         if (Core_Reset_o !== ~Done_o) begin
            errors++;
            $display("FAIL core_reset_vs_done: Core_Reset_o=%b Done_o=%b", Core_Reset_o, Done_o);
         end
      end
   end

   // Reference model: expected writes and outcome from the stream alone.
   task automatic build_expected(input bq_t s, output bit exp_done);
      int n;
      logic [31:0] w;
      logic [7:0]  x;
      exp_addr_q.delete();
      exp_data_q.delete();
      n = int'({s[1], s[0]});
      exp_done = 1'b0;
      if (n == 0 || n > DEPTH) return;
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
         w = 32'd0;
         for (int j = 0; j < 4; j++) begin
            w = w | (32'(s[2 + 4*k + j]) << (8*j));
            x = x ^ s[2 + 4*k + j];
         end
         exp_addr_q.push_back(32'(4*k));
         exp_data_q.push_back(w);
      end
`ifdef LOADER_CHECKSUM_EN
      exp_done = (s[2 + 4*n] == x);
`else
      exp_done = 1'b1;
`endif
   endtask

   // Appends the correct checksum byte when the checksum feature is built in.
   task automatic add_csum(inout bq_t s);
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      for (int i = 2; i < s.size(); i++) x = x ^ s[i];
      s.push_back(x);
`endif
   endtask

   task automatic compare_writes(input string name);
      checks++;
      if (wr_addr_q.size() != exp_addr_q.size()) begin
         errors++;
         $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), exp_addr_q.size());
      end else begin
         for (int i = 0; i < exp_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
               errors++;
               $display("FAIL %s write[%0d]: got %h@%h required %h@%h", name, i,
                        wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
            end
         end
      end
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   // Drives a stream; returns edges until Done_o/Error_o, bytes consumed and
   // whether the bound expired. abort_at >= 0 stops after that many bytes.
   task automatic run_load(input bq_t s, input bit do_start, input bit gaps,
                           input int abort_at, output int cycles,
                           output int consumed, output bit timed_out);
      int  i = 0;
      int  cyc = 0;
      bit  v, rdy;
      timed_out = 1'b1;
      Start_i = do_start;
      while (cyc < 3000) begin
         if (abort_at >= 0 && i == abort_at) begin
            timed_out = 1'b0;
            break;
         end
         v = (i < s.size()) && (!gaps || $urandom_range(0, 3) != 0);
         Byte_Valid_i = v;
         Byte_Data_i  = (i < s.size()) ? s[i] : 8'h00;
         @(negedge clk);
         rdy = Byte_Ready_o;
         @(posedge clk);
         #1;
         cyc++;
         Start_i = 1'b0;
         if (v && rdy) i++;
         if (Done_o === 1'b1 || Error_o === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
      Byte_Valid_i = 1'b0;
      Start_i      = 1'b0;
      cycles       = cyc;
      consumed     = i;
   endtask

   task automatic expect_outcome(input string name, input bit exp_done,
                                 input bit timed_out, input int consumed, input int size);
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL %s timeout: no Done_o/Error_o within bound", name);
      end
      checks++;
      if (Done_o !== exp_done || Error_o !== !exp_done) begin
         errors++;
         $display("FAIL %s outcome: Done_o=%b Error_o=%b required Done_o=%b", name, Done_o, Error_o, exp_done);
      end
      checks++;
      if (consumed != size) begin
         errors++;
         $display("FAIL %s consumed: got %0d bytes required %0d", name, consumed, size);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o, Core_Reset_o, Done_o, Error_o}
          !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: rdy=%b wr=%b addr=%h data=%h crst=%b done=%b err=%b",
                  Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o, Core_Reset_o, Done_o, Error_o);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (Core_Reset_o !== 1'b1 || Byte_Ready_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: Core_Reset_o=%b Byte_Ready_o=%b required 1/0", Core_Reset_o, Byte_Ready_o);
      end
   endtask

   task automatic test_basic();
      bq_t s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h31, 8'h00};
      bit  exp_done, to;
      int  cyc, used;
      add_csum(s);
      build_expected(s, exp_done);
      run_load(s, 1'b1, 1'b0, -1, cyc, used, to);
      expect_outcome("basic", exp_done, to, used, s.size());
      checks++;
      if (cyc != 3 + 5*2 + CSUM_EXTRA) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles required %0d", cyc, 3 + 5*2 + CSUM_EXTRA);
      end
      checks++;
      if (exp_data_q[0] !== 32'h00500093 || exp_data_q[1] !== 32'h00310113) begin
         errors++;
         $display("FAIL basic_model: got %h %h required 00500093 00310113", exp_data_q[0], exp_data_q[1]);
      end
      compare_writes("basic");
   endtask

   task automatic test_bad_header(input logic [7:0] lo, input logic [7:0] hi, input string name);
      bq_t s;
      bit  exp_done, to;
      int  cyc, used;
      s.push_back(lo);
      s.push_back(hi);
      build_expected(s, exp_done);
      run_load(s, 1'b1, 1'b0, -1, cyc, used, to);
      expect_outcome(name, exp_done, to, used, s.size());
      @(negedge clk);
      checks++;
      if (Core_Reset_o !== 1'b1 || Byte_Ready_o !== 1'b0 || Error_o !== 1'b1) begin
         errors++;
         $display("FAIL %s hold: Core_Reset_o=%b Byte_Ready_o=%b Error_o=%b required 1/0/1",
                  name, Core_Reset_o, Byte_Ready_o, Error_o);
      end
      compare_writes(name);
   endtask

   task automatic test_full_random();
      bq_t s = '{8'd64, 8'd0};
      bit  exp_done, to;
      int  cyc, used;
      for (int i = 0; i < 4*DEPTH; i++) s.push_back(8'($urandom));
      add_csum(s);
      build_expected(s, exp_done);
      run_load(s, 1'b1, 1'b1, -1, cyc, used, to);
      expect_outcome("full_random", exp_done, to, used, s.size());
      checks++;
      if (Mem_Address_o !== 32'h0000_00FC) begin
         errors++;
         $display("FAIL full_last_addr: got %h required 000000fc", Mem_Address_o);
      end
      compare_writes("full_random");
   endtask

   task automatic test_reset_midload();
      bq_t s = '{8'h02, 8'h00};
      bq_t s2 = '{8'h01, 8'h00};
      bit  exp_done, to;
      int  cyc, used;
      for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
      add_csum(s);
      run_load(s, 1'b1, 1'b0, 8, cyc, used, to);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o, Core_Reset_o, Done_o, Error_o}
          !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midload_reset: rdy=%b wr=%b addr=%h data=%h crst=%b done=%b err=%b",
                  Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o, Core_Reset_o, Done_o, Error_o);
      end
      wr_addr_q.delete();
      wr_data_q.delete();
      for (int i = 0; i < 4; i++) s2.push_back(8'($urandom));
      add_csum(s2);
      build_expected(s2, exp_done);
      run_load(s2, 1'b1, 1'b1, -1, cyc, used, to);
      expect_outcome("after_reset", exp_done, to, used, s2.size());
      compare_writes("after_reset");
   endtask

   task automatic test_restart();
      bq_t s = '{8'h03, 8'h00};
      bit  exp_done, to;
      int  cyc, used;
      Start_i = 1'b1;
      Byte_Valid_i = 1'b0;
      @(posedge clk);
      #1;
      Start_i = 1'b0;
      checks++;
      if (Core_Reset_o !== 1'b1 || Done_o !== 1'b0 || Byte_Ready_o !== 1'b1) begin
         errors++;
         $display("FAIL restart_edge: Core_Reset_o=%b Done_o=%b Byte_Ready_o=%b required 1/0/1",
                  Core_Reset_o, Done_o, Byte_Ready_o);
      end
      for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
      add_csum(s);
      build_expected(s, exp_done);
      run_load(s, 1'b0, 1'b1, -1, cyc, used, to);
      expect_outcome("restart", exp_done, to, used, s.size());
      compare_writes("restart");
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum(input logic [7:0] cs, input string name);
      bq_t s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      bit  exp_done, to;
      int  cyc, used;
      s.push_back(cs);
      build_expected(s, exp_done);
      run_load(s, 1'b1, 1'b0, -1, cyc, used, to);
      expect_outcome(name, exp_done, to, used, s.size());
      compare_writes(name);
   endtask
`endif

   initial begin
      reset        = 1'b1;
      Start_i      = 1'b0;
      Byte_Valid_i = 1'b0;
      Byte_Data_i  = 8'h00;
      test_reset();
      test_basic();
      test_restart();
      test_bad_header(8'h00, 8'h00, "hdr_zero");
      test_bad_header(8'h41, 8'h00, "hdr_65");
      test_full_random();
      test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
      test_checksum(8'h08, "csum_ok");
      test_checksum(8'h09, "csum_bad");
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
